// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type and GF(2^8) multiply helpers
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB,
        ST_DRAIN,
        ST_MIX,
        ST_DONE
    } state_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [BYTE_W-1:0] gf_xtime(input logic [BYTE_W-1:0] a);
        return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul09(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul0b(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul0d(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul0e(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2, x4, x8;
        x2 = gf_xtime(a);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - registered 256-entry inverse S-box ROM, one cycle latency
module inv_sbox
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic [BYTE_W-1:0] in,
    output logic [BYTE_W-1:0] out
);

    // Entry 0 is the leftmost byte of the constant
    localparam logic [0:255][BYTE_W-1:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    always_ff @(posedge clk) begin
        out <= INV_SBOX[in];
    end

endmodule

// File: rtl/aes_inv_sub_mix_word.sv
// rtl/aes_inv_sub_mix_word.sv - byte-serial InvSubBytes + optional InvMixColumns on one column
module aes_inv_sub_mix_word
    import aes_pkg::*;
#(
    parameter bit MIX = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word
);

    state_t            state, state_nx;
    logic [1:0]        cnt;
    logic [WORD_W-1:0] col_q;
    logic [BYTE_W-1:0] col_b [4];
    logic [BYTE_W-1:0] sub_b [4];
    logic [BYTE_W-1:0] sbox_in, sbox_out;
    logic [WORD_W-1:0] sub_word, mix_word, out_q;

    for (genvar i = 0; i < 4; i++) begin : g_bytes
        assign col_b[i] = col_q[WORD_W-1-BYTE_W*i -: BYTE_W];
    end

    assign sbox_in  = col_b[cnt];
    assign sub_word = {sub_b[0], sub_b[1], sub_b[2], sub_b[3]};
    assign out_word = out_q;

    inv_sbox u_inv_sbox (
        .clk (clk),
        .in  (sbox_in),
        .out (sbox_out)
    );

    // Row r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
    always_comb begin
        mix_word = {
            gf_mul0e(sub_b[0]) ^ gf_mul0b(sub_b[1]) ^ gf_mul0d(sub_b[2]) ^ gf_mul09(sub_b[3]),
            gf_mul0e(sub_b[1]) ^ gf_mul0b(sub_b[2]) ^ gf_mul0d(sub_b[3]) ^ gf_mul09(sub_b[0]),
            gf_mul0e(sub_b[2]) ^ gf_mul0b(sub_b[3]) ^ gf_mul0d(sub_b[0]) ^ gf_mul09(sub_b[1]),
            gf_mul0e(sub_b[3]) ^ gf_mul0b(sub_b[0]) ^ gf_mul0d(sub_b[1]) ^ gf_mul09(sub_b[2])
        };
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_SUB;
            end
            ST_SUB:   if (cnt == 2'd3) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_MIX;
            ST_MIX:   state_nx = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // The ROM result for byte cnt-1 appears while byte cnt is being issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            col_q <= '0;
            out_q <= '0;
            for (int i = 0; i < 4; i++) sub_b[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        col_q <= in_word;
                        cnt   <= 2'd0;
                    end
                end
                ST_SUB: begin
                    if (cnt != 2'd0) sub_b[cnt - 2'd1] <= sbox_out;
                    cnt <= cnt + 2'd1;
                end
                ST_DRAIN: sub_b[3] <= sbox_out;
                ST_MIX:   out_q <= MIX ? mix_word : sub_word;
                default: ;
            endcase
        end
    end

endmodule
